// File: rtl/vehicular_emissions_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : vehicular_emissions_fsm_if
// Brief    : CO2 sample in, warning/critical status out for the emissions FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface vehicular_emissions_fsm_if;
    logic [7:0] CO2_level;
    logic       warning;
    logic       critical;

    // master drives samples and observes status; slave is the FSM itself
    modport master (
        output CO2_level,
        input  warning,
        input  critical
    );

    modport slave (
        input  CO2_level,
        output warning,
        output critical
    );
endinterface : vehicular_emissions_fsm_if
`default_nettype wire

// File: rtl/vehicular_emissions_fsm.sv
`default_nettype none
// ============================================================================
// Module   : vehicular_emissions_fsm
// Brief    : Three-state Moore classifier of CO2 readings (NORMAL/WARNING/
//            CRITICAL). Optional consecutive-sample debounce via the macro
//            EMISSIONS_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vehicular_emissions_fsm #(
    parameter int WARN_TH         = 50,
    parameter int CRIT_TH         = 100,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  wire                        clk,
    input  wire                        reset,
    vehicular_emissions_fsm_if.slave   bus
);

    generate
        if (!((WARN_TH > 0) && (WARN_TH < CRIT_TH) && (CRIT_TH <= 255))) begin : g_th_check
            $error("vehicular_emissions_fsm: thresholds must satisfy 0 < WARN_TH < CRIT_TH <= 255");
        end
        if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 15)) begin : g_db_check
            $error("vehicular_emissions_fsm: DEBOUNCE_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'b00,
        ST_WARNING  = 2'b01,
        ST_CRITICAL = 2'b10
    } state_t;

    localparam logic [7:0] c_warn_th = 8'(WARN_TH);
    localparam logic [7:0] c_crit_th = 8'(CRIT_TH);

    state_t r_state;
    state_t w_next_state;
    state_t w_band;

    always_comb begin
        w_band = ST_NORMAL;
        if (bus.CO2_level >= c_crit_th) begin
            w_band = ST_CRITICAL;
        end else if (bus.CO2_level >= c_warn_th) begin
            w_band = ST_WARNING;
        end
    end

`ifdef EMISSIONS_DEBOUNCE_EN
    localparam logic [3:0] c_debounce = 4'(DEBOUNCE_CYCLES);

    state_t     r_cand;
    state_t     w_next_cand;
    logic [3:0] r_count;
    logic [3:0] w_next_count;
    logic [3:0] w_tally;

    always_comb begin
        w_next_state = r_state;
        w_next_cand  = r_cand;
        w_next_count = r_count;
        w_tally      = 4'd1;
        case (r_state)
            ST_NORMAL, ST_WARNING, ST_CRITICAL: begin
                if (w_band == r_state) begin
                    w_next_count = 4'd0;
                end else begin
                    // a sample in a different band than the running candidate restarts at 1
                    if ((w_band == r_cand) && (r_count != 4'd0)) begin
                        w_tally = r_count + 4'd1;
                    end
                    w_next_cand = w_band;
                    if (w_tally >= c_debounce) begin
                        w_next_state = w_band;
                        w_next_count = 4'd0;
                    end else begin
                        w_next_count = w_tally;
                    end
                end
            end
            default: begin
                w_next_state = ST_NORMAL;
                w_next_cand  = ST_NORMAL;
                w_next_count = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_NORMAL;
            r_cand  <= ST_NORMAL;
            r_count <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cand  <= w_next_cand;
            r_count <= w_next_count;
        end
    end
`else
    // band is always a legal encoding, so a stray 2'b11 clears on the next edge
    always_comb begin
        w_next_state = w_band;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_next_state;
        end
    end
`endif

    assign bus.warning  = (r_state == ST_WARNING);
    assign bus.critical = (r_state == ST_CRITICAL);

endmodule : vehicular_emissions_fsm
`default_nettype wire

// File: tb/tb_vehicular_emissions_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_vehicular_emissions_fsm
// Brief    : Directed self-checking bench for vehicular_emissions_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vehicular_emissions_fsm;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    vehicular_emissions_fsm_if bus ();

    vehicular_emissions_fsm #(
        .WARN_TH         (50),
        .CRIT_TH         (100),
        .DEBOUNCE_CYCLES (3)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] exp_wc);
        logic [1:0] obs;
        obs = {bus.warning, bus.critical};
        n_checks++;
        assert (obs === exp_wc) n_pass++;
        else $error("FAIL %s: observed (w,c)=%b required (w,c)=%b", tag, obs, exp_wc);
    endtask

    // drive one sample, let one rising edge take it, then look 1ns later
    task automatic apply(input logic [7:0] val);
        bus.CO2_level = val;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] band_of(input int v);
        if (v >= 100)     return 2'b01;
        else if (v >= 50) return 2'b10;
        else              return 2'b00;
    endfunction

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.CO2_level = 8'd0;

        #1;
        chk("reset_held", 2'b00);
        @(posedge clk);
        #1;
        chk("reset_edge", 2'b00);
        reset = 1'b0;
        chk("after_release", 2'b00);
        apply(8'd0);
        chk("first_edge_0", 2'b00);

`ifndef EMISSIONS_DEBOUNCE_EN
        apply(8'd30);  chk("seq_30",  2'b00);
        apply(8'd70);  chk("seq_70",  2'b10);
        apply(8'd120); chk("seq_120", 2'b01);
        apply(8'd40);  chk("seq_40_c2n", 2'b00);

        apply(8'd99);  chk("bnd_99",  2'b10);
        apply(8'd100); chk("bnd_100", 2'b01);
        apply(8'd50);  chk("bnd_50",  2'b10);
        apply(8'd49);  chk("bnd_49",  2'b00);
        apply(8'd51);  chk("hyst_51", 2'b10);
        apply(8'd49);  chk("hyst_49", 2'b00);
        apply(8'd255); chk("n2c_255", 2'b01);
        apply(8'd0);   chk("c2n_0",   2'b00);

        // latency: change input mid-cycle, outputs must not move before the edge
        bus.CO2_level = 8'd70;
        #2;
        chk("no_comb_path", 2'b00);
        @(posedge clk);
        #1;
        chk("one_cycle_lat", 2'b10);

        // asynchronous reset from CRITICAL with input held high
        apply(8'd200); chk("pre_reset_crit", 2'b01);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_now", 2'b00);
        @(posedge clk);
        #1;
        chk("reset_ignores_in", 2'b00);
        reset = 1'b0;
        chk("release_no_edge", 2'b00);
        @(posedge clk);
        #1;
        chk("post_reset_crit", 2'b01);

        // asynchronous reset from WARNING
        apply(8'd60); chk("pre_reset_warn", 2'b10);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_warn", 2'b00);
        #1;
        reset = 1'b0;
        apply(8'd10); chk("post_reset_norm", 2'b00);

        for (int v = 0; v < 256; v++) begin
            apply(8'(v));
            chk($sformatf("sweep_%0d", v), band_of(v));
            n_checks++;
            assert (!(bus.warning && bus.critical)) n_pass++;
            else $error("FAIL sweep_excl_%0d: observed w=%b c=%b required not both 1",
                        v, bus.warning, bus.critical);
        end
`else
        apply(8'd70);  chk("db_70_1", 2'b00);
        apply(8'd70);  chk("db_70_2", 2'b00);
        apply(8'd30);  chk("db_30_clr", 2'b00);
        apply(8'd70);  chk("db_70_a", 2'b00);
        apply(8'd70);  chk("db_70_b", 2'b00);
        apply(8'd70);  chk("db_70_c", 2'b10);
        apply(8'd120); chk("db_120_1", 2'b10);
        apply(8'd70);  chk("db_70_hold", 2'b10);
        apply(8'd120); chk("db_120_a", 2'b10);
        apply(8'd120); chk("db_120_b", 2'b10);
        apply(8'd120); chk("db_120_c", 2'b01);
        apply(8'd0);   chk("db_0_1", 2'b01);
        #2;
        reset = 1'b1;
        #1;
        chk("db_async_reset", 2'b00);
        reset = 1'b0;
        apply(8'd120); chk("db_cnt_cleared_1", 2'b00);
        apply(8'd120); chk("db_cnt_cleared_2", 2'b00);
        apply(8'd120); chk("db_cnt_cleared_3", 2'b01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_vehicular_emissions_fsm
`default_nettype wire

// File: doc/vehicular_emissions_fsm.md
VEHICULAR_EMISSIONS_FSM -- requirements
Module: vehicular_emissions_fsm

Interface
REQ-001 Parameter WARN_TH, default 50: lowest CO2_level code classified as warning band.
REQ-002 Parameter CRIT_TH, default 100: lowest CO2_level code classified as critical band.
REQ-003 Parameter DEBOUNCE_CYCLES, default 3: consecutive samples needed to change state when EMISSIONS_DEBOUNCE_EN is defined; range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 CO2_level  input  8  unsigned CO2 reading, 0..255, sampled every rising clk edge.
REQ-007 warning  output  1  high while FSM is in WARNING.
REQ-008 critical  output  1  high while FSM is in CRITICAL.

Function
REQ-009 The FSM SHALL have exactly three encoded states: NORMAL, WARNING, CRITICAL; unused encodings SHALL recover to NORMAL on the next edge.
REQ-010 Band classification SHALL be combinational: CO2_level < WARN_TH -> NORMAL band; WARN_TH <= CO2_level < CRIT_TH -> WARNING band; CO2_level >= CRIT_TH -> CRITICAL band.
REQ-011 Comparisons SHALL be unsigned 8-bit; 255 classifies as CRITICAL, 0 as NORMAL.
REQ-012 Without debounce, next state SHALL equal the band of CO2_level sampled at each rising edge; any state may move to any other state in one edge (e.g. NORMAL -> CRITICAL, CRITICAL -> NORMAL directly).
REQ-013 Outputs SHALL be Moore, decoded from the state register only: NORMAL -> warning=0, critical=0; WARNING -> warning=1, critical=0; CRITICAL -> warning=0, critical=1.
REQ-014 warning and critical SHALL never both be 1.
REQ-015 Latency: an input change SHALL appear on outputs after the first rising edge at which it is sampled (one-cycle latency, no combinational input-to-output path).
REQ-016 Boundary values: 49 -> NORMAL, 50 -> WARNING, 99 -> WARNING, 100 -> CRITICAL (default parameters).
REQ-017 No hysteresis: alternating 49/51/49 SHALL alternate NORMAL/WARNING/NORMAL on successive edges.
REQ-018 Parameters SHALL satisfy 0 < WARN_TH < CRIT_TH <= 255; violation SHALL be flagged at elaboration.

Reset
REQ-019 Asserting reset SHALL immediately force state NORMAL, warning=0, critical=0, and debounce counter to 0, independent of clk.
REQ-020 While reset is high, CO2_level SHALL be ignored; the first sample SHALL be taken at the first rising edge after reset deasserts.
REQ-021 Reset asserted mid-operation (any state, any counter value) SHALL behave identically to power-on reset.

Configuration
REQ-022 Macro EMISSIONS_DEBOUNCE_EN: when undefined, behaviour SHALL be exactly REQ-012 and no debounce counter SHALL be built.
REQ-023 When EMISSIONS_DEBOUNCE_EN is defined, a 4-bit counter SHALL count consecutive edges whose sampled band equals one candidate band differing from the current state; a sample in another band SHALL restart the count for that band; the state SHALL change at the edge completing DEBOUNCE_CYCLES consecutive samples, after which the counter SHALL clear.
REQ-024 With debounce enabled, a sample in the current state's band SHALL clear the counter; outputs SHALL still follow REQ-013.

Verification
REQ-025 reset=1 for 1 cycle with CO2_level=0, release -> warning=0, critical=0 before and after the first edge.
REQ-026 Sequence 30, 70, 120, 40 one per cycle -> (w,c) = (0,0), (1,0), (0,1), (0,0), each one edge after the sample.
REQ-027 Boundaries 99, 100, 50, 49 -> WARNING, CRITICAL, WARNING, NORMAL; then 51, 49 -> WARNING, NORMAL.
REQ-028 CO2_level=200 held, assert reset between edges -> outputs drop to (0,0) immediately without a clock edge; release -> CRITICAL after the next edge.
REQ-029 EMISSIONS_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=3: samples 70, 70, 30, 70, 70, 70 from NORMAL -> state stays NORMAL until the sixth edge, then warning=1.
REQ-030 Sweep CO2_level 0..255 -> warning/critical match REQ-010 band at each value and are never both high.
